text_console_writer: RTL

//  Hardware text console feeding the 80x30 VGA text-mode VRAM. Accepts a byte stream (valid/ready),

---
 rtl/text_console_pkg.sv | 29 ++
 rtl/console_cursor.sv | 58 +++++
 rtl/text_console_writer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/text_console_pkg.sv
// Shared types and constants for the VRAM text console writer.
package text_console_pkg;

   localparam int COLS_DEF = 80;
   localparam int ROWS_DEF = 30;

   localparam logic [6:0] CC_BS = 7'h08;
   localparam logic [6:0] CC_LF = 7'h0A;
   localparam logic [6:0] CC_FF = 7'h0C;
   localparam logic [6:0] CC_CR = 7'h0D;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PUT,
      ST_CLR,
      ST_SCR_RD,
      ST_SCR_WT,
      ST_SCR_WR,
      ST_FILL
   } state_t;

   function automatic logic [15:0] pack_half(input logic       inv,
                                             input logic [6:0] code,
                                             input logic [3:0] fg,
                                             input logic [3:0] bg);
      return {inv, code, fg, bg};
   endfunction

endpackage

// File: rtl/console_cursor.sv
// Cursor column/row counters; the row saturates at the bottom line, and the flags tell the
// caller when an advance or newline needs a scroll instead.
module console_cursor
   import text_console_pkg::*;
#(
   parameter int COLS = COLS_DEF,
   parameter int ROWS = ROWS_DEF
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       inc,
   input  logic       newline,
   input  logic       cr,
   input  logic       back,
   input  logic       home,
   output logic [6:0] col,
   output logic [4:0] row,
   output logic       inc_ovf,
   output logic       nl_ovf
);

   localparam logic [6:0] COL_LAST = 7'(COLS - 1);
   localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);

   assign nl_ovf  = (row == ROW_LAST);
   assign inc_ovf = nl_ovf && (col == COL_LAST);

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         col <= '0;
         row <= '0;
      end else if (home) begin
         col <= '0;
         row <= '0;
      end else if (newline) begin
         col <= '0;
         if (!nl_ovf) row <= row + 5'd1;
      end else if (cr) begin
         col <= '0;
      end else if (inc) begin
         if (col == COL_LAST) begin
            col <= '0;
            if (!nl_ovf) row <= row + 5'd1;
         end else begin
            col <= col + 7'd1;
         end
      end else if (back) begin
         // Backing up from column 0 lands on the last cell of the previous row; (0,0) stays put.
         if (col != 7'd0) begin
            col <= col - 7'd1;
         end else if (row != 5'd0) begin
            col <= COL_LAST;
            row <= row - 5'd1;
         end
      end
   end

endmodule

// File: rtl/text_console_writer.sv
// Byte-stream text console writing glyph/attribute halfwords into VRAM over Avalon-MM, with clear and scroll.
// Printable char: bus write one cycle after accept, ready again the cycle after; CHAR_READY low while busy or stalled.
module text_console_writer
   import text_console_pkg::*;
#(
   parameter int          COLS       = COLS_DEF,
   parameter int          ROWS       = ROWS_DEF,
   parameter logic [11:0] VRAM_BASE  = 12'h0,
   parameter logic [6:0]  BLANK_CODE = 7'h20
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        CHAR_VALID,
   output logic        CHAR_READY,
   input  logic [7:0]  CHAR_DATA,
   input  logic [3:0]  ATTR_FG,
   input  logic [3:0]  ATTR_BG,
   output logic [11:0] M_ADDR,
   output logic        M_READ,
   output logic        M_WRITE,
   output logic [3:0]  M_BYTE_EN,
   output logic [31:0] M_WRITEDATA,
   input  logic [31:0] M_READDATA,
   input  logic        M_READDATAVALID,
   input  logic        M_WAITREQUEST,
   output logic [6:0]  CURSOR_COL,
   output logic [4:0]  CURSOR_ROW,
   output logic        BUSY
);

   localparam logic [10:0] W_FIRST = 11'(COLS / 2);
   localparam logic [10:0] W_LAST  = 11'(ROWS * COLS / 2 - 1);
   localparam logic [10:0] W_FILL  = 11'((ROWS - 1) * COLS / 2);

   state_t      state_q, state_nxt;
   logic        rdy_en_q;
   logic [7:0]  chr_q;
   logic [3:0]  fg_q, bg_q;
   logic        adv_q, adv_nxt;
   logic [10:0] wcnt_q, wcnt_ld_val;
   logic [31:0] rd_q;

   logic        xfer, is_ctl, acc;
   logic        ld_char, wcnt_ld, wcnt_inc, rd_ld;
   logic        cur_inc, cur_nl, cur_cr, cur_back, cur_home, inc_ovf, nl_ovf;
   logic [11:0] cidx;
   logic [15:0] blank_h, glyph_h;

   console_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
      .CLK     (CLK),
      .RESET   (RESET),
      .inc     (cur_inc),
      .newline (cur_nl),
      .cr      (cur_cr),
      .back    (cur_back),
      .home    (cur_home),
      .col     (CURSOR_COL),
      .row     (CURSOR_ROW),
      .inc_ovf (inc_ovf),
      .nl_ovf  (nl_ovf)
   );

   assign CHAR_READY = rdy_en_q && (state_q == ST_IDLE);
   assign BUSY       = (state_q != ST_IDLE);
   assign xfer       = CHAR_VALID && CHAR_READY;
   assign is_ctl     = !CHAR_DATA[7];
   assign acc        = !M_WAITREQUEST;

   assign cidx    = 12'(CURSOR_ROW) * 12'(COLS) + 12'(CURSOR_COL);
   assign blank_h = pack_half(1'b0, BLANK_CODE, fg_q, bg_q);
   // A backspace reuses PUT with a blank glyph and no cursor advance afterwards.
   assign glyph_h = adv_q ? pack_half(chr_q[7], chr_q[6:0], fg_q, bg_q) : blank_h;

   always_comb begin
      state_nxt   = state_q;
      adv_nxt     = adv_q;
      ld_char     = 1'b0;
      wcnt_ld     = 1'b0;
      wcnt_ld_val = '0;
      wcnt_inc    = 1'b0;
      rd_ld       = 1'b0;
      cur_inc     = 1'b0;
      cur_nl      = 1'b0;
      cur_cr      = 1'b0;
      cur_back    = 1'b0;
      cur_home    = 1'b0;
      M_ADDR      = '0;
      M_READ      = 1'b0;
      M_WRITE     = 1'b0;
      M_BYTE_EN   = '0;
      M_WRITEDATA = '0;

      unique case (state_q)
         ST_IDLE: begin
            if (xfer) begin
               ld_char = 1'b1;
               if (is_ctl && CHAR_DATA[6:0] == CC_CR) begin
                  cur_cr = 1'b1;
               end else if (is_ctl && CHAR_DATA[6:0] == CC_LF) begin
                  cur_nl = 1'b1;
                  if (nl_ovf) begin
                     wcnt_ld     = 1'b1;
                     wcnt_ld_val = W_FIRST;
                     state_nxt   = ST_SCR_RD;
                  end
               end else if (is_ctl && CHAR_DATA[6:0] == CC_BS) begin
                  if (CURSOR_COL != 7'd0 || CURSOR_ROW != 5'd0) begin
                     cur_back  = 1'b1;
                     adv_nxt   = 1'b0;
                     state_nxt = ST_PUT;
                  end
               end else if (is_ctl && CHAR_DATA[6:0] == CC_FF) begin
                  cur_home    = 1'b1;
                  wcnt_ld     = 1'b1;
                  wcnt_ld_val = '0;
                  state_nxt   = ST_CLR;
               end else begin
                  adv_nxt   = 1'b1;
                  state_nxt = ST_PUT;
               end
            end
         end
         ST_PUT: begin
            M_WRITE = 1'b1;
            M_ADDR  = VRAM_BASE + {1'b0, cidx[11:1]};
            if (cidx[0]) begin
               M_BYTE_EN   = 4'b1100;
               M_WRITEDATA = {glyph_h, 16'h0000};
            end else begin
               M_BYTE_EN   = 4'b0011;
               M_WRITEDATA = {16'h0000, glyph_h};
            end
            if (acc) begin
               state_nxt = ST_IDLE;
               if (adv_q) begin
                  cur_inc = 1'b1;
                  if (inc_ovf) begin
                     wcnt_ld     = 1'b1;
                     wcnt_ld_val = W_FIRST;
                     state_nxt   = ST_SCR_RD;
                  end
               end
            end
         end
         ST_CLR, ST_FILL: begin
            M_WRITE     = 1'b1;
            M_ADDR      = VRAM_BASE + {1'b0, wcnt_q};
            M_BYTE_EN   = 4'hF;
            M_WRITEDATA = {blank_h, blank_h};
            if (acc) begin
               if (wcnt_q == W_LAST) state_nxt = ST_IDLE;
               else                  wcnt_inc  = 1'b1;
            end
         end
         ST_SCR_RD: begin
            M_READ = 1'b1;
            M_ADDR = VRAM_BASE + {1'b0, wcnt_q};
            if (acc) state_nxt = ST_SCR_WT;
         end
         ST_SCR_WT: begin
            if (M_READDATAVALID) begin
               rd_ld     = 1'b1;
               state_nxt = ST_SCR_WR;
            end
         end
         ST_SCR_WR: begin
            M_WRITE     = 1'b1;
            M_ADDR      = VRAM_BASE + {1'b0, wcnt_q - W_FIRST};
            M_BYTE_EN   = 4'hF;
            M_WRITEDATA = rd_q;
            if (acc) begin
               if (wcnt_q == W_LAST) begin
                  wcnt_ld     = 1'b1;
                  wcnt_ld_val = W_FILL;
                  state_nxt   = ST_FILL;
               end else begin
                  wcnt_inc  = 1'b1;
                  state_nxt = ST_SCR_RD;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q  <= ST_IDLE;
         rdy_en_q <= 1'b0;
         chr_q    <= '0;
         fg_q     <= '0;
         bg_q     <= '0;
         adv_q    <= 1'b0;
         wcnt_q   <= '0;
         rd_q     <= '0;
      end else begin
         state_q  <= state_nxt;
         rdy_en_q <= 1'b1;
         adv_q    <= adv_nxt;
         if (ld_char) begin
            chr_q <= CHAR_DATA;
            fg_q  <= ATTR_FG;
            bg_q  <= ATTR_BG;
         end
         if (wcnt_ld)       wcnt_q <= wcnt_ld_val;
         else if (wcnt_inc) wcnt_q <= wcnt_q + 11'd1;
         if (rd_ld) rd_q <= M_READDATA;
      end
   end

endmodule
